// File: rtl/dcache_wb_assoc.sv
// Set-associative write-back / write-allocate data cache controller (tags + state only).
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_op/
//   cmd_addr                        command handshake from the trace driver
//   mem_req/mem_we/mem_addr/mem_ack line request to the next level (held until acked)
//   hit_cnt..wb_cnt                 statistics counters (wrap on overflow)
// After reset, and after a clear command, every set is swept clean, one set per cycle.
module dcache_wb_assoc #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned OFFSET_W = 6,
  parameter int unsigned INDEX_W  = 14,
  parameter int unsigned WAYS     = 4,
  parameter int unsigned WAY_W    = 2,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [3:0]                 cmd_op,
  input  logic [ADDR_W-1:0]          cmd_addr,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [ADDR_W-OFFSET_W-1:0] mem_addr,
  input  logic                       mem_ack,
  output logic [CNT_W-1:0]           hit_cnt,
  output logic [CNT_W-1:0]           miss_cnt,
  output logic [CNT_W-1:0]           read_cnt,
  output logic [CNT_W-1:0]           write_cnt,
  output logic [CNT_W-1:0]           wb_cnt
);

  localparam int unsigned SETS   = 1 << INDEX_W;
  localparam int unsigned LINE_W = ADDR_W - OFFSET_W;
  localparam int unsigned TAG_W  = LINE_W - INDEX_W;

  localparam logic [3:0] OpRead  = 4'd0;
  localparam logic [3:0] OpWrite = 4'd1;
  localparam logic [3:0] OpInval = 4'd3;
  localparam logic [3:0] OpClear = 4'd8;

  typedef enum logic [2:0] {StClear, StIdle, StLookup, StWb, StFill} state_e;
  typedef logic [WAYS-1:0][WAY_W-1:0] age_row_t;
  typedef logic [WAYS-1:0][TAG_W-1:0] tag_row_t;

  state_e              state_q, state_d;
  logic [INDEX_W-1:0]  ptr_q, ptr_d;
  logic [3:0]          op_q, op_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [WAY_W-1:0]    way_q, way_d;
  logic                mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [LINE_W-1:0]   mem_addr_q, mem_addr_d;
  logic [CNT_W-1:0]    hit_q, hit_d, miss_q, miss_d, rd_q, rd_d, wr_q, wr_d, wb_q, wb_d;

  // Tag/state arrays: contents are defined by the clear sweep, so no reset is needed.
  logic [WAYS-1:0] valid_q [SETS];
  logic [WAYS-1:0] dirty_q [SETS];
  tag_row_t        tag_q   [SETS];
  age_row_t        age_q   [SETS];

  logic               wr_en;
  logic [INDEX_W-1:0] wr_idx;
  logic [WAYS-1:0]    wr_valid_d, wr_dirty_d;
  tag_row_t           wr_tag_d;
  age_row_t           wr_age_d;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic [WAYS-1:0]    rd_valid, rd_dirty;
  tag_row_t           rd_tag;
  age_row_t           rd_age;
  logic               hit;
  logic [WAY_W-1:0]   hit_way, vic_way;
  logic               unused_offset;

  assign unused_offset = ^cmd_addr[OFFSET_W-1:0];
  assign idx      = line_q[INDEX_W-1:0];
  assign tag      = line_q[LINE_W-1:INDEX_W];
  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_age   = age_q[idx];

  // Touched way becomes youngest; only ways younger than it age by one.
  function automatic age_row_t lru_touch(input age_row_t age, input logic [WAY_W-1:0] k);
    age_row_t res;
    for (int w = 0; w < int'(WAYS); w++) begin
      res[w] = (age[w] < age[k]) ? age[w] + WAY_W'(1) : age[w];
    end
    res[k] = '0;
    return res;
  endfunction

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    vic_way = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (rd_age[w] == WAY_W'(WAYS - 1)) vic_way = WAY_W'(w);
    end
    // Descending scan so the lowest-index invalid way wins.
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (!rd_valid[w]) vic_way = WAY_W'(w);
    end
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (rd_valid[w] && (rd_tag[w] == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StClear;
      ptr_q      <= '0;
      op_q       <= '0;
      line_q     <= '0;
      way_q      <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      hit_q      <= '0;
      miss_q     <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      wb_q       <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      op_q       <= op_d;
      line_q     <= line_d;
      way_q      <= way_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      wb_q       <= wb_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      valid_q[wr_idx] <= wr_valid_d;
      dirty_q[wr_idx] <= wr_dirty_d;
      tag_q[wr_idx]   <= wr_tag_d;
      age_q[wr_idx]   <= wr_age_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    op_d       = op_q;
    line_d     = line_q;
    way_d      = way_q;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    hit_d      = hit_q;
    miss_d     = miss_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    wb_d       = wb_q;
    wr_en      = 1'b0;
    wr_idx     = idx;
    wr_valid_d = rd_valid;
    wr_dirty_d = rd_dirty;
    wr_tag_d   = rd_tag;
    wr_age_d   = rd_age;
    case (state_q)
      StClear: begin
        wr_en      = 1'b1;
        wr_idx     = ptr_q;
        wr_valid_d = '0;
        wr_dirty_d = '0;
        for (int w = 0; w < int'(WAYS); w++) wr_age_d[w] = WAY_W'(w);
        ptr_d = ptr_q + INDEX_W'(1);
        if (ptr_q == '1) state_d = StIdle;
      end
      StIdle: begin
        if (cmd_valid) begin
          if (cmd_op == OpClear) begin
            state_d = StClear;
            ptr_d   = '0;
            hit_d   = '0;
            miss_d  = '0;
            rd_d    = '0;
            wr_d    = '0;
            wb_d    = '0;
          end else begin
            op_d    = cmd_op;
            line_d  = cmd_addr[ADDR_W-1:OFFSET_W];
            state_d = StLookup;
          end
        end
      end
      StLookup: begin
        state_d = StIdle;
        if ((op_q == OpRead) || (op_q == OpWrite)) begin
          if (op_q == OpRead) rd_d = rd_q + CNT_W'(1);
          else                wr_d = wr_q + CNT_W'(1);
          if (hit) begin
            hit_d    = hit_q + CNT_W'(1);
            wr_en    = 1'b1;
            wr_age_d = lru_touch(rd_age, hit_way);
            if (op_q == OpWrite) wr_dirty_d[hit_way] = 1'b1;
          end else begin
            miss_d    = miss_q + CNT_W'(1);
            way_d     = vic_way;
            mem_req_d = 1'b1;
            if (rd_valid[vic_way] && rd_dirty[vic_way]) begin
              state_d    = StWb;
              mem_we_d   = 1'b1;
              mem_addr_d = {rd_tag[vic_way], idx};
            end else begin
              state_d    = StFill;
              mem_we_d   = 1'b0;
              mem_addr_d = line_q;
            end
          end
        end else if ((op_q == OpInval) && hit) begin
          way_d = hit_way;
          if (rd_dirty[hit_way]) begin
            state_d    = StWb;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b1;
            mem_addr_d = line_q;
          end else begin
            wr_en               = 1'b1;
            wr_valid_d[hit_way] = 1'b0;
          end
        end
      end
      StWb: begin
        if (mem_req_q && mem_ack) begin
          // Request drops for a cycle; FILL re-raises it with the fill address.
          mem_req_d         = 1'b0;
          mem_we_d          = 1'b0;
          wb_d              = wb_q + CNT_W'(1);
          wr_en             = 1'b1;
          wr_dirty_d[way_q] = 1'b0;
          if (op_q == OpInval) begin
            wr_valid_d[way_q] = 1'b0;
            state_d           = StIdle;
          end else begin
            state_d = StFill;
          end
        end
      end
      StFill: begin
        if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = line_q;
        end else if (mem_ack) begin
          mem_req_d         = 1'b0;
          wr_en             = 1'b1;
          wr_tag_d[way_q]   = tag;
          wr_valid_d[way_q] = 1'b1;
          wr_dirty_d[way_q] = (op_q == OpWrite);
          wr_age_d          = lru_touch(rd_age, way_q);
          state_d           = StIdle;
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == StIdle);
    mem_req   = mem_req_q;
    mem_we    = mem_we_q;
    mem_addr  = mem_addr_q;
    hit_cnt   = hit_q;
    miss_cnt  = miss_q;
    read_cnt  = rd_q;
    write_cnt = wr_q;
    wb_cnt    = wb_q;
  end

endmodule

// File: tb/tb_dcache_wb_assoc.sv
module tb_dcache_wb_assoc;
  localparam int unsigned ADDR_W = 32, OFFSET_W = 6, INDEX_W = 2, WAYS = 4, WAY_W = 2;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned LINE_W = ADDR_W - OFFSET_W, TAG_W = LINE_W - INDEX_W;
  localparam int unsigned SETS = 1 << INDEX_W;

  logic              clk, rst_n, cmd_valid, cmd_ready, mem_req, mem_we, mem_ack;
  logic [3:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LINE_W-1:0] mem_addr;
  logic [CNT_W-1:0]  hit_cnt, miss_cnt, read_cnt, write_cnt, wb_cnt;

  dcache_wb_assoc #(
    .ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W), .INDEX_W(INDEX_W),
    .WAYS(WAYS), .WAY_W(WAY_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
    .read_cnt(read_cnt), .write_cnt(write_cnt), .wb_cnt(wb_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: each set holds up to WAYS resident lines; eviction picks the
  // resident line with the oldest use stamp.
  bit              m_valid [SETS][WAYS];
  bit              m_dirty [SETS][WAYS];
  logic [TAG_W-1:0] m_tag  [SETS][WAYS];
  int              m_stamp [SETS][WAYS];
  int              now;
  logic [CNT_W-1:0] m_hit, m_miss, m_rd, m_wr, m_wb;
  int              exp_n;
  logic            exp_we   [4];
  logic [LINE_W-1:0] exp_addr [4];
  int              n_obs, last_cyc;
  logic            obs_we   [8];
  logic [LINE_W-1:0] obs_addr [8];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", name, got, want);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < int'(SETS); s++)
      for (int w = 0; w < int'(WAYS); w++) begin
        m_valid[s][w] = 0;
        m_dirty[s][w] = 0;
      end
    m_hit = 0; m_miss = 0; m_rd = 0; m_wr = 0; m_wb = 0;
  endtask

  task automatic expect_tx(input logic we, input logic [LINE_W-1:0] a);
    exp_we[exp_n]   = we;
    exp_addr[exp_n] = a;
    exp_n++;
  endtask

  task automatic model_apply(input logic [3:0] op, input logic [ADDR_W-1:0] addr);
    logic [LINE_W-1:0]  line;
    logic [INDEX_W-1:0] s;
    logic [TAG_W-1:0]   t;
    int h, slot;
    line = addr[ADDR_W-1:OFFSET_W];
    s = line[INDEX_W-1:0];
    t = line[LINE_W-1:INDEX_W];
    exp_n = 0;
    now++;
    h = -1;
    for (int w = 0; w < int'(WAYS); w++)
      if (m_valid[s][w] && m_tag[s][w] == t) h = w;
    if (op == 4'd0 || op == 4'd1) begin
      if (op == 4'd0) m_rd++; else m_wr++;
      if (h >= 0) begin
        m_hit++;
        m_stamp[s][h] = now;
        if (op == 4'd1) m_dirty[s][h] = 1;
      end else begin
        m_miss++;
        slot = -1;
        for (int w = 0; w < int'(WAYS); w++) if (!m_valid[s][w] && slot < 0) slot = w;
        if (slot < 0) begin
          slot = 0;
          for (int w = 1; w < int'(WAYS); w++)
            if (m_stamp[s][w] < m_stamp[s][slot]) slot = w;
          if (m_dirty[s][slot]) begin
            expect_tx(1'b1, {m_tag[s][slot], s});
            m_wb++;
          end
        end
        expect_tx(1'b0, line);
        m_valid[s][slot] = 1;
        m_tag[s][slot]   = t;
        m_dirty[s][slot] = (op == 4'd1);
        m_stamp[s][slot] = now;
      end
    end else if (op == 4'd3) begin
      if (h >= 0) begin
        if (m_dirty[s][h]) begin
          expect_tx(1'b1, line);
          m_wb++;
        end
        m_valid[s][h] = 0;
        m_dirty[s][h] = 0;
      end
    end else if (op == 4'd8) begin
      model_reset();
    end
  endtask

  task automatic check_counters();
    check("hit_cnt", hit_cnt, m_hit);
    check("miss_cnt", miss_cnt, m_miss);
    check("read_cnt", read_cnt, m_rd);
    check("write_cnt", write_cnt, m_wr);
    check("wb_cnt", wb_cnt, m_wb);
  endtask

  // Called at a negedge; returns at a negedge with cmd_ready high (or after a timeout).
  task automatic run_cmd(input logic [3:0] op, input logic [ADDR_W-1:0] addr, input int delay);
    int cyc, wait_left;
    bit req_seen, just_acked;
    logic rec_we;
    logic [LINE_W-1:0] rec_addr;
    model_apply(op, addr);
    for (int i = 0; i < 8; i++) begin obs_we[i] = 1'b0; obs_addr[i] = '0; end
    cyc = 0;
    while (!cmd_ready && cyc < 100) begin @(negedge clk); cyc++; end
    check("ready_before_cmd", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    n_obs = 0; cyc = 0; req_seen = 0; just_acked = 0; wait_left = 0;
    rec_we = 1'b0; rec_addr = '0;
    while (cyc < 400) begin
      @(negedge clk);
      cyc++;
      mem_ack = 1'b0;
      if (just_acked) begin
        check("req_drop_after_ack", mem_req, 1'b0);
        just_acked = 0;
      end
      if (cmd_ready) break;
      if (mem_req) begin
        if (!req_seen) begin
          req_seen = 1;
          rec_we = mem_we;
          rec_addr = mem_addr;
          wait_left = (delay >= 0) ? delay : int'($urandom_range(0, 3));
          if (n_obs < 8) begin obs_we[n_obs] = mem_we; obs_addr[n_obs] = mem_addr; end
          check("tx_expected", (n_obs < exp_n) ? 1'b1 : 1'b0, 1'b1);
          if (n_obs < exp_n) begin
            check("tx_we", mem_we, exp_we[n_obs]);
            check("tx_addr", mem_addr, exp_addr[n_obs]);
          end
        end else begin
          check("tx_hold", {cmd_ready, mem_we, mem_addr}, {1'b0, rec_we, rec_addr});
        end
        if (wait_left == 0) begin
          mem_ack = 1'b1;
          req_seen = 0;
          just_acked = 1;
          n_obs++;
        end else begin
          wait_left--;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        mem_ack = 1'b1;  // stray ack with no request outstanding
      end
    end
    mem_ack = 1'b0;
    last_cyc = cyc;
    check("cmd_done_in_time", cmd_ready, 1'b1);
    check("tx_count", n_obs, exp_n);
    if (exp_n == 0) check("latency", cyc, (op == 4'd8) ? SETS + 1 : 2);
    check_counters();
  endtask

  task automatic reset_release();
    int n;
    check("rst_ready", cmd_ready, 1'b0);
    check("rst_req", mem_req, 1'b0);
    check("rst_we", mem_we, 1'b0);
    check("rst_addr", mem_addr, 0);
    check_counters();
    rst_n = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!cmd_ready && n < 40);
    check("sweep_cycles", n, SETS);
    check_counters();
    @(negedge clk);
  endtask

  initial begin
    logic [3:0]        op;
    logic [ADDR_W-1:0] a;
    int cyc;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; mem_ack = 1'b0;
    now = 0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_release();

    run_cmd(4'd0, 32'h0000_0040, -1);
    check("tp_fill_addr", obs_addr[0], 26'h1);
    check("tp_fill_we", obs_we[0], 1'b0);
    run_cmd(4'd0, 32'h0000_0040, -1);
    check("tp_hit_cnt", hit_cnt, 1);
    check("tp_read_cnt", read_cnt, 2);
    check("tp_hit_no_req", n_obs, 0);

    run_cmd(4'd8, 32'h0, -1);
    for (int i = 0; i < 5; i++) run_cmd(4'd1, 32'h40 + 32'h100 * i, -1);
    check("tp_evict_we", obs_we[0], 1'b1);
    check("tp_evict_addr", obs_addr[0], 26'h1);
    check("tp_refill_addr", obs_addr[1], 26'h11);
    check("tp_wb_cnt", wb_cnt, 1);
    check("tp_miss_cnt", miss_cnt, 5);

    run_cmd(4'd8, 32'h0, -1);
    for (int i = 0; i < 4; i++) run_cmd(4'd1, 32'h40 + 32'h100 * i, -1);
    run_cmd(4'd0, 32'h40, -1);
    run_cmd(4'd1, 32'h440, -1);
    check("tp_lru_victim", obs_addr[0], 26'h5);

    run_cmd(4'd3, 32'h440, -1);
    check("tp_inval_wb", obs_addr[0], 26'h11);
    check("tp_inval_wb_cnt", wb_cnt, 2);
    run_cmd(4'd0, 32'h440, -1);
    check("tp_read_after_inval", obs_addr[0], 26'h11);

    run_cmd(4'd0, 32'h0000_2080, 10);
    run_cmd(4'd5, 32'h0000_2080, -1);

    // Reset in the middle of a fill.
    cmd_valid = 1'b1; cmd_op = 4'd0; cmd_addr = 32'h3000_00C0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    cyc = 0;
    while (!mem_req && cyc < 20) begin @(negedge clk); cyc++; end
    check("midfill_req", mem_req, 1'b1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("midfill_req_drop", mem_req, 1'b0);
    model_reset();
    @(negedge clk);
    reset_release();
    run_cmd(4'd0, 32'h3000_00C0, -1);

    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 19))
        0, 1, 2, 3, 4, 5, 6, 7:        op = 4'd0;
        8, 9, 10, 11, 12, 13, 14:      op = 4'd1;
        15, 16, 17:                    op = 4'd3;
        18:                            op = 4'd6;
        default:                       op = 4'd8;
      endcase
      a = {24'($urandom_range(0, 5)), 2'($urandom_range(0, 3)), 6'($urandom_range(0, 63))};
      run_cmd(op, a, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
